// File: rtl/ps2_voice_allocator.sv
// rtl/ps2_voice_allocator.sv - PS/2 scan-code decoder and polyphonic voice allocator
// Lowest free voice first, otherwise steal the oldest; break codes release the voice holding the key.
module ps2_voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int AGE_W      = 4
) (
    input  logic                    sys_clk,
    input  logic                    reset,
    input  logic                    code_valid,
    input  logic [7:0]              code_data,
    input  logic                    all_off,
    output logic [NUM_VOICES-1:0]   voice_on,
    output logic [8*NUM_VOICES-1:0] voice_code,
    output logic [NUM_VOICES-1:0]   voice_trig,
    output logic                    steal_evt,
    output logic [3:0]              active_count
);

    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BREAK,
        ST_EXT,
        ST_EXT_BREAK
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_make_evt;
    logic   w_break_evt;

    logic [NUM_VOICES-1:0] r_voice_on;
    logic [7:0]            r_voice_code [NUM_VOICES];
    logic [AGE_W-1:0]      r_age        [NUM_VOICES];
    logic [NUM_VOICES-1:0] r_trig;
    logic                  r_steal;
    logic [3:0]            r_count;

    logic [NUM_VOICES-1:0] w_on_nxt;
    logic [7:0]            w_code_nxt [NUM_VOICES];
    logic [AGE_W-1:0]      w_age_nxt  [NUM_VOICES];
    logic [NUM_VOICES-1:0] w_trig_nxt;
    logic                  w_steal_nxt;
    logic [3:0]            w_count_nxt;

    logic             w_hit;
    logic [IDX_W-1:0] w_hit_idx;
    logic             w_free;
    logic [IDX_W-1:0] w_free_idx;
    logic [IDX_W-1:0] w_old_idx;
    logic [AGE_W-1:0] w_old_age;
    logic [IDX_W-1:0] w_sel_idx;
    logic             w_is_note;

    function automatic logic is_note(input logic [7:0] c);
        case (c)
            8'h1A, 8'h1B, 8'h22, 8'h23, 8'h21, 8'h2A, 8'h34,
            8'h32, 8'h33, 8'h31, 8'h3B, 8'h3A, 8'h41: is_note = 1'b1;
            default:                                  is_note = 1'b0;
        endcase
    endfunction

    // Keyboard status/ack bytes that must never be taken as key presses
    function automatic logic is_status(input logic [7:0] c);
        case (c)
            8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: is_status = 1'b1;
            default:                                  is_status = 1'b0;
        endcase
    endfunction

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_make_evt  = 1'b0;
        w_break_evt = 1'b0;
        if (all_off) begin
            w_state_nxt = ST_IDLE;
        end else if (code_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (code_data == 8'hF0)      w_state_nxt = ST_BREAK;
                    else if (code_data == 8'hE0) w_state_nxt = ST_EXT;
                    else if (!is_status(code_data)) w_make_evt = 1'b1;
                end
                ST_BREAK: begin
                    if (code_data == 8'hF0) begin
                        w_state_nxt = ST_BREAK;
                    end else if (code_data == 8'hE0) begin
                        w_state_nxt = ST_EXT_BREAK;
                    end else begin
                        w_break_evt = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_EXT: begin
                    if (code_data == 8'hF0) w_state_nxt = ST_EXT_BREAK;
                    else                    w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Holder lookup, lowest free voice, and oldest voice (strict > keeps the lowest index on ties)
    always_comb begin
        w_hit      = 1'b0;
        w_hit_idx  = '0;
        w_free     = 1'b0;
        w_free_idx = '0;
        w_old_idx  = '0;
        w_old_age  = r_age[0];
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!w_hit && r_voice_on[i] && (r_voice_code[i] == code_data)) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
            if (!w_free && !r_voice_on[i]) begin
                w_free     = 1'b1;
                w_free_idx = IDX_W'(i);
            end
            if (r_age[i] > w_old_age) begin
                w_old_age = r_age[i];
                w_old_idx = IDX_W'(i);
            end
        end
    end

    assign w_sel_idx = w_free ? w_free_idx : w_old_idx;
    assign w_is_note = is_note(code_data);

    always_comb begin
        w_on_nxt    = r_voice_on;
        w_code_nxt  = r_voice_code;
        w_age_nxt   = r_age;
        w_trig_nxt  = '0;
        w_steal_nxt = 1'b0;
        if (all_off) begin
            w_on_nxt = '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                w_age_nxt[i] = '0;
            end
        end else if (w_make_evt && w_is_note && !w_hit) begin
            w_steal_nxt = !w_free;
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (IDX_W'(i) == w_sel_idx) begin
                    w_on_nxt[i]   = 1'b1;
                    w_code_nxt[i] = code_data;
                    w_age_nxt[i]  = '0;
                    w_trig_nxt[i] = 1'b1;
                end else if (r_voice_on[i] && (r_age[i] != AGE_MAX)) begin
                    w_age_nxt[i] = r_age[i] + 1'b1;
                end
            end
        end else if (w_break_evt && w_is_note && w_hit) begin
            // Pitch stays in voice_code so the release envelope can finish the note
            w_on_nxt[w_hit_idx]  = 1'b0;
            w_age_nxt[w_hit_idx] = '0;
        end
    end

    always_comb begin
        w_count_nxt = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            w_count_nxt = w_count_nxt + 4'(w_on_nxt[i]);
        end
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            r_voice_on <= '0;
            r_trig     <= '0;
            r_steal    <= 1'b0;
            r_count    <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_voice_code[i] <= '0;
                r_age[i]        <= '0;
            end
        end else begin
            r_voice_on   <= w_on_nxt;
            r_voice_code <= w_code_nxt;
            r_age        <= w_age_nxt;
            r_trig       <= w_trig_nxt;
            r_steal      <= w_steal_nxt;
            r_count      <= w_count_nxt;
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_code
        assign voice_code[8*g +: 8] = r_voice_code[g];
    end

    assign voice_on     = r_voice_on;
    assign voice_trig   = r_trig;
    assign steal_evt    = r_steal;
    assign active_count = r_count;

endmodule

// File: tb/tb_ps2_voice_allocator.sv
// tb/tb_ps2_voice_allocator.sv - self-checking bench for ps2_voice_allocator
// Directed scenarios followed by randomized byte streams against a timestamp-based reference model.
module tb_ps2_voice_allocator;

    localparam int NV = 4;

    logic            sys_clk = 1'b0;
    logic            reset;
    logic            code_valid;
    logic [7:0]      code_data;
    logic            all_off;
    logic [NV-1:0]   voice_on;
    logic [8*NV-1:0] voice_code;
    logic [NV-1:0]   voice_trig;
    logic            steal_evt;
    logic [3:0]      active_count;

    ps2_voice_allocator #(.NUM_VOICES(NV), .AGE_W(4)) dut (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .code_valid   (code_valid),
        .code_data    (code_data),
        .all_off      (all_off),
        .voice_on     (voice_on),
        .voice_code   (voice_code),
        .voice_trig   (voice_trig),
        .steal_evt    (steal_evt),
        .active_count (active_count)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: age of an active voice = assignments made since it was assigned, capped
    logic [7:0] notes [13] = '{8'h1A, 8'h1B, 8'h22, 8'h23, 8'h21, 8'h2A, 8'h34,
                               8'h32, 8'h33, 8'h31, 8'h3B, 8'h3A, 8'h41};
    bit         m_on    [NV];
    logic [7:0] m_code  [NV];
    int         m_stamp [NV];
    int         n_assign;
    int         pst;
    logic [NV-1:0] m_trig;
    bit         m_steal;

    function automatic bit note_code(input logic [7:0] c);
        for (int i = 0; i < 13; i++) if (notes[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int holder(input logic [7:0] c);
        for (int i = 0; i < NV; i++) if (m_on[i] && m_code[i] == c) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_on[i] = 0; m_code[i] = 8'h00; m_stamp[i] = 0;
        end
        n_assign = 0; pst = 0; m_trig = '0; m_steal = 0;
    endtask

    task automatic model_step(input bit cv, input logic [7:0] b, input bit off);
        bit mk = 0, bk = 0;
        m_trig = '0; m_steal = 0;
        if (off) begin
            for (int i = 0; i < NV; i++) m_on[i] = 0;
            pst = 0;
        end else if (cv) begin
            case (pst)
                0: if (b == 8'hF0) pst = 1;
                   else if (b == 8'hE0) pst = 2;
                   else if (!(b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) mk = 1;
                1: if (b == 8'hE0) pst = 3;
                   else if (b != 8'hF0) begin bk = 1; pst = 0; end
                2: pst = (b == 8'hF0) ? 3 : 0;
                default: pst = 0;
            endcase
        end
        if (mk && note_code(b) && holder(b) < 0) begin
            int sel = -1;
            for (int i = 0; i < NV; i++) if (sel < 0 && !m_on[i]) sel = i;
            if (sel < 0) begin
                int best = -1;
                for (int i = 0; i < NV; i++) begin
                    int a = n_assign - m_stamp[i] - 1;
                    if (a > NV - 1) a = NV - 1;
                    if (a > best) begin best = a; sel = i; end
                end
                m_steal = 1;
            end
            m_on[sel] = 1; m_code[sel] = b; m_stamp[sel] = n_assign;
            n_assign++;
            m_trig[sel] = 1'b1;
        end
        if (bk && note_code(b) && holder(b) >= 0) m_on[holder(b)] = 0;
    endtask

    task automatic check_all(input string tag);
        logic [NV-1:0]   e_on = '0;
        logic [8*NV-1:0] e_code = '0;
        logic [3:0]      e_cnt = '0;
        for (int i = 0; i < NV; i++) begin
            e_on[i] = m_on[i];
            e_code[8*i +: 8] = m_code[i];
            e_cnt = e_cnt + 4'(m_on[i]);
        end
        check($sformatf("%s.voice_on", tag), 64'(voice_on), 64'(e_on));
        check($sformatf("%s.voice_code", tag), 64'(voice_code), 64'(e_code));
        check($sformatf("%s.voice_trig", tag), 64'(voice_trig), 64'(m_trig));
        check($sformatf("%s.steal_evt", tag), 64'(steal_evt), 64'(m_steal));
        check($sformatf("%s.active_count", tag), 64'(active_count), 64'(e_cnt));
    endtask

    task automatic send(input bit cv, input logic [7:0] b, input bit off, input string tag);
        @(negedge sys_clk);
        code_valid = cv; code_data = b; all_off = off;
        @(posedge sys_clk);
        model_step(cv, b, off);
        #1;
        check_all(tag);
    endtask

    task automatic key(input logic [7:0] b, input string tag);
        send(1'b1, b, 1'b0, tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge sys_clk);
        code_valid = 0; all_off = 0;
        reset = 1'b0;
        #2;
        model_reset();
        check_all(tag);
        @(negedge sys_clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b1; code_valid = 0; code_data = 8'h00; all_off = 0;
        model_reset();
        do_reset("reset");

        key(8'h1A, "fill0"); check("fill0.trig", 64'(voice_trig), 64'h1);
        key(8'h22, "fill1"); check("fill1.trig", 64'(voice_trig), 64'h2);
        key(8'h21, "fill2"); check("fill2.trig", 64'(voice_trig), 64'h4);
        check("fill.on", 64'(voice_on), 64'h7);
        check("fill.count", 64'(active_count), 64'd3);
        key(8'h2A, "fill3");
        key(8'h34, "steal");
        check("steal.evt", 64'(steal_evt), 64'h1);
        check("steal.trig", 64'(voice_trig), 64'h1);
        check("steal.code0", 64'(voice_code[7:0]), 64'h34);
        send(0, 8'h00, 0, "idle");

        send(0, 8'h00, 1, "off1");
        key(8'h1A, "typ0"); check("typ0.trig", 64'(voice_trig), 64'h1);
        key(8'h1A, "typ1"); check("typ1.trig", 64'(voice_trig), 64'h0);
        key(8'h1A, "typ2"); check("typ2.count", 64'(active_count), 64'd1);

        send(0, 8'h00, 1, "off2");
        key(8'h1A, "rel0"); key(8'h22, "rel1"); key(8'hF0, "rel2"); key(8'h1A, "rel3");
        check("rel.on", 64'(voice_on), 64'h2);
        check("rel.code0", 64'(voice_code[7:0]), 64'h1A);
        key(8'h23, "reuse");
        check("reuse.trig", 64'(voice_trig), 64'h1);
        check("reuse.code0", 64'(voice_code[7:0]), 64'h23);

        send(0, 8'h00, 1, "off3");
        key(8'hE0, "ext0"); key(8'h1A, "ext1");
        key(8'hE0, "ext2"); key(8'hF0, "ext3"); key(8'h1A, "ext4");
        key(8'h29, "non0"); key(8'hF0, "non1"); key(8'h29, "non2");
        check("ext.on", 64'(voice_on), 64'h0);
        key(8'h22, "after_ext");
        check("after_ext.trig", 64'(voice_trig), 64'h1);

        key(8'h1A, "h1"); key(8'h21, "h2");
        send(1, 8'h33, 1, "off_cv");
        check("off_cv.on", 64'(voice_on), 64'h0);
        check("off_cv.count", 64'(active_count), 64'd0);
        check("off_cv.trig", 64'(voice_trig), 64'h0);
        key(8'hF0, "pre_rst");
        do_reset("mid_reset");
        key(8'h1A, "post_rst");
        check("post_rst.on", 64'(voice_on), 64'h1);

        for (int n = 0; n < 3000; n++) begin
            int r = $urandom_range(0, 99);
            logic [7:0] b;
            if (r < 60)      b = notes[$urandom_range(0, 12)];
            else if (r < 75) b = 8'hF0;
            else if (r < 83) b = 8'hE0;
            else if (r < 90) b = 8'hFA;
            else             b = 8'($urandom);
            if ($urandom_range(0, 199) == 0) do_reset("rand_rst");
            else send($urandom_range(0, 3) != 0, b, $urandom_range(0, 49) == 0, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
